// File: rtl/hazard_controller.sv
// hazard_controller
// -----------------
// Hazard and sequencing controller for a five-stage MIPS pipeline.
// Each cycle it produces the stall, flush and forwarding selects for the
// F/D/E/M/W pipeline registers, and it freezes the whole pipeline while a
// variable-latency data memory is busy.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   rsD, rtD                   decode-stage source registers
//   rsE, rtE                   execute-stage source registers
//   writeregE/M/W              destination register per stage
//   regwriteE/M/W              register-write enable per stage
//   memtoregE, memtoregM       load instruction in E / M
//   branchD, jumpD, pcsrcD     branch, jump, branch taken (decode)
//   memaccessM, memreadyM      M-stage memory access / memory done this cycle
//   stallF/D/E/M               hold the register feeding the named stage
//   flushD/E/W                 bubble the named stage's input register
//   forwardAD, forwardBD       decode compare operand from aluoutM
//   forwardAE, forwardBE       ALU operand: 00 regfile, 01 resultW, 10 aluoutM
//   memtimeout                 sticky flag: memory hung (FSM in ERR)
//   stallcount                 saturating count of cycles with stallF=1
//
// Every output except stallcount/memtimeout is combinational from the
// current inputs and FSM state.
module hazard_controller #(
    parameter int WAIT_TIMEOUT = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeregE,
    input  logic [4:0]       writeregM,
    input  logic [4:0]       writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             branchD,
    input  logic             jumpD,
    input  logic             pcsrcD,
    input  logic             memaccessM,
    input  logic             memreadyM,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             memtimeout,
    output logic [CNT_W-1:0] stallcount
);

    // Wide enough to hold WAIT_TIMEOUT-1 with margin.
    localparam int WC_W = $clog2(WAIT_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WC_W-1:0] waitcnt;
    logic [WC_W-1:0] waitcnt_next;

    logic            lwstall;
    logic            branchstall;
    logic            hazstall;
    logic            memstall;
    logic [1:0]      fwd_ae;
    logic [1:0]      fwd_be;
    logic            fwd_ad;
    logic            fwd_bd;

    // ------------------------------------------------------------------
    // Wait-state FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            waitcnt <= '0;
        end else begin
            state   <= state_next;
            waitcnt <= waitcnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Wait-state FSM: next state
    // waitcnt counts the not-ready cycles of the current access; the first
    // one is spent in RUN, so it is loaded with 1 on entry to WAIT.
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        waitcnt_next = waitcnt;
        case (state)
            RUN: begin
                if (memaccessM && !memreadyM) begin
                    state_next   = WAIT;
                    waitcnt_next = WC_W'(1);
                end
            end
            WAIT: begin
                if (memreadyM) begin
                    state_next   = RUN;
                    waitcnt_next = '0;
                end else if (waitcnt == WC_W'(WAIT_TIMEOUT - 1)) begin
                    state_next   = ERR;
                end else begin
                    waitcnt_next = waitcnt + WC_W'(1);
                end
            end
            ERR: begin
                // Only reset leaves ERR.
                state_next = ERR;
            end
            default: begin
                state_next   = RUN;
                waitcnt_next = '0;
            end
        endcase
    end

    assign memtimeout = (state == ERR);

    // ------------------------------------------------------------------
    // Forwarding. M stage has priority over W: it holds the younger value.
    // ------------------------------------------------------------------
    always_comb begin
        fwd_ae = 2'b00;
        if (rsE != 5'd0 && regwriteM && writeregM == rsE) begin
            fwd_ae = 2'b10;
        end else if (rsE != 5'd0 && regwriteW && writeregW == rsE) begin
            fwd_ae = 2'b01;
        end

        fwd_be = 2'b00;
        if (rtE != 5'd0 && regwriteM && writeregM == rtE) begin
            fwd_be = 2'b10;
        end else if (rtE != 5'd0 && regwriteW && writeregW == rtE) begin
            fwd_be = 2'b01;
        end
    end

    assign fwd_ad = (rsD != 5'd0) && regwriteM && (writeregM == rsD);
    assign fwd_bd = (rtD != 5'd0) && regwriteM && (writeregM == rtD);

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign lwstall = memtoregE && ((rtE == rsD) || (rtE == rtD));

    // A branch resolves in decode, so it must wait for an ALU result still
    // in E, or for a load result still in M.
    assign branchstall = branchD &&
        ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
         (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));

    assign hazstall = lwstall || branchstall;

    // In WAIT with memreadyM=1 (completion cycle) this is 0, so pipeline
    // hazards are honoured in that same cycle.
    assign memstall = (state == ERR) || (memaccessM && !memreadyM);

    // ------------------------------------------------------------------
    // Output selection. Reset forces bubbles everywhere; a memory freeze
    // holds every stage and suppresses D/E flushes so frozen contents
    // survive, overriding load-use and branch stalls.
    // ------------------------------------------------------------------
    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushW    = 1'b0;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (reset) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushW = 1'b1;
        end else begin
            forwardAD = fwd_ad;
            forwardBD = fwd_bd;
            forwardAE = fwd_ae;
            forwardBE = fwd_be;
            if (memstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else begin
                stallF = hazstall;
                stallD = hazstall;
                flushE = hazstall;
                // A taken branch/jump held in decode must not squash
                // itself; the flush waits until decode advances.
                flushD = (pcsrcD || jumpD) && !hazstall;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stallcount <= '0;
        end else if (stallF && (stallcount != {CNT_W{1'b1}})) begin
            stallcount <= stallcount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller (WAIT_TIMEOUT=4, CNT_W=4).
// Each cycle the bench drives inputs shortly after the rising edge, pushes
// the expected outputs onto exp_q, and pops/compares them on the falling
// edge of the same cycle.
module tb_hazard_controller;

    localparam int WT = 4;
    localparam int CW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [4:0]    rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic          regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic          branchD, jumpD, pcsrcD, memaccessM, memreadyM;
    logic          stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic          forwardAD, forwardBD, memtimeout;
    logic [1:0]    forwardAE, forwardBE;
    logic [CW-1:0] stallcount;

    hazard_controller #(.WAIT_TIMEOUT(WT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .jumpD(jumpD), .pcsrcD(pcsrcD),
        .memaccessM(memaccessM), .memreadyM(memreadyM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .memtimeout(memtimeout), .stallcount(stallcount)
    );

    // ---------------- scoreboard state ----------------
    // exp_q entry: {ctrl[13:0], stallcount[3:0]}
    // ctrl: 13 stallF,12 stallD,11 stallE,10 stallM,9 flushD,8 flushE,
    //       7 flushW,6 forwardAD,5 forwardBD,4:3 forwardAE,2:1 forwardBE,
    //       0 memtimeout
    logic [17:0]   exp_q[$];
    logic [CW-1:0] sc_model;
    int            n_cmp = 0;
    int            n_err = 0;

    logic [13:0] IDLE, STL, FRZ, RST;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [13:0] mk(input logic sf, sd, se, sm, fd, fe, fw, ad, bd,
                                       input logic [1:0] ae, be, input logic mt);
        return {sf, sd, se, sm, fd, fe, fw, ad, bd, ae, be, mt};
    endfunction

    // Expected outputs in RUN with no memory access, straight from the rules.
    function automatic logic [13:0] model_run();
        logic [1:0] ae, be;
        logic       lw, br, st, fd, ad, bd;
        ae = (rsE != 0 && regwriteM && writeregM == rsE) ? 2'b10 :
             (rsE != 0 && regwriteW && writeregW == rsE) ? 2'b01 : 2'b00;
        be = (rtE != 0 && regwriteM && writeregM == rtE) ? 2'b10 :
             (rtE != 0 && regwriteW && writeregW == rtE) ? 2'b01 : 2'b00;
        lw = memtoregE && (rtE == rsD || rtE == rtD);
        br = branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                         (memtoregM && (writeregM == rsD || writeregM == rtD)));
        st = lw | br;
        fd = (pcsrcD | jumpD) & ~st;
        ad = (rsD != 0) && regwriteM && (writeregM == rsD);
        bd = (rtD != 0) && regwriteM && (writeregM == rtD);
        return mk(st, st, 1'b0, 1'b0, fd, st, 1'b0, ad, bd, ae, be, 1'b0);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0;
        branchD = 0; jumpD = 0; pcsrcD = 0;
        memaccessM = 0; memreadyM = 0;
    endtask

    // One cycle: inputs are already driven; push expectation, compare at
    // the falling edge, advance the stall-count model, move to next cycle.
    task automatic step(input string name, input logic [13:0] e);
        logic [17:0] x;
        exp_q.push_back({e, sc_model});
        @(negedge clk);
        x = exp_q.pop_front();
        check({name, ".stallF"},     32'(stallF),     32'(x[17]));
        check({name, ".stallD"},     32'(stallD),     32'(x[16]));
        check({name, ".stallE"},     32'(stallE),     32'(x[15]));
        check({name, ".stallM"},     32'(stallM),     32'(x[14]));
        check({name, ".flushD"},     32'(flushD),     32'(x[13]));
        check({name, ".flushE"},     32'(flushE),     32'(x[12]));
        check({name, ".flushW"},     32'(flushW),     32'(x[11]));
        check({name, ".forwardAD"},  32'(forwardAD),  32'(x[10]));
        check({name, ".forwardBD"},  32'(forwardBD),  32'(x[9]));
        check({name, ".forwardAE"},  32'(forwardAE),  32'(x[8:7]));
        check({name, ".forwardBE"},  32'(forwardBE),  32'(x[6:5]));
        check({name, ".memtimeout"}, 32'(memtimeout), 32'(x[4]));
        check({name, ".stallcount"}, 32'(stallcount), 32'(x[3:0]));
        if (reset) sc_model = '0;
        else if (e[13] && sc_model != {CW{1'b1}}) sc_model = sc_model + 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        IDLE = '0;
        STL  = mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        FRZ  = mk(1, 1, 1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0);
        RST  = mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        sc_model = '0;
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;

        // Reset forces outputs even with hazards present.
        memtoregE = 1; rtE = 8; rsD = 8; rsE = 8; regwriteM = 1; writeregM = 8; jumpD = 1;
        step("rst_force", RST);
        step("rst_hold", RST);
        reset = 0;
        clear_inputs();
        step("idle", IDLE);

        // Execute forwarding priority
        rsE = 5; writeregM = 5; writeregW = 5; regwriteM = 1; regwriteW = 1;
        step("fwd_m", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0));
        regwriteM = 0;
        step("fwd_w", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0));
        rsE = 0;
        step("fwd_zero", IDLE);
        clear_inputs();
        rtE = 7; writeregW = 7; regwriteW = 1; rsD = 6; rtD = 6; writeregM = 6; regwriteM = 1;
        step("fwd_b_dec", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b01, 0));

        // Load-use: one bubble; jump held in decode is not flushed meanwhile
        clear_inputs();
        memtoregE = 1; rtE = 8; rsD = 8; jumpD = 1;
        step("lw_stall", STL);
        clear_inputs();
        memtoregM = 1; regwriteM = 1; writeregM = 8; rsD = 8; rsE = 8; jumpD = 1;
        step("lw_after", mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 0));

        // Branch on E-stage ALU result: one stall, then resolve with flush
        clear_inputs();
        branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3; pcsrcD = 1;
        step("br_stall", STL);
        clear_inputs();
        branchD = 1; rsD = 3; regwriteM = 1; writeregM = 3; pcsrcD = 1;
        step("br_resolve", mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0));

        // Branch on load in E: two stall cycles
        clear_inputs();
        branchD = 1; rsD = 4; memtoregE = 1; rtE = 4; regwriteE = 1; writeregE = 4;
        step("brlw_1", STL);
        clear_inputs();
        branchD = 1; rsD = 4; memtoregM = 1; regwriteM = 1; writeregM = 4;
        step("brlw_2", mk(1, 1, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0));
        clear_inputs();
        branchD = 1; rsD = 4; regwriteW = 1; writeregW = 4; pcsrcD = 1;
        step("brlw_3", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));

        // Memory wait 3 cycles with a pending load-use hazard underneath
        clear_inputs();
        memaccessM = 1; memtoregE = 1; rtE = 9; rsD = 9; jumpD = 1;
        for (int i = 0; i < 3; i++) step("mem_wait", FRZ);
        memreadyM = 1;
        step("mem_done", STL);
        clear_inputs();
        step("mem_idle", IDLE);

        // Zero-wait access
        memaccessM = 1; memreadyM = 1;
        step("zero_wait", IDLE);
        clear_inputs();
        step("zero_after", IDLE);

        // Reset in the middle of a wait restarts the timeout window
        memaccessM = 1;
        step("mw_1", FRZ);
        step("mw_2", FRZ);
        reset = 1;
        step("rst_midwait", RST);
        reset = 0;
        for (int i = 0; i < WT - 1; i++) step("mw_post", FRZ);
        memreadyM = 1;
        step("mw_done", IDLE);
        clear_inputs();

        // Timeout: sticky until reset
        memaccessM = 1;
        for (int i = 0; i < WT; i++) step("to_wait", FRZ);
        memreadyM = 1;
        step("to_flag", FRZ | 14'd1);
        memaccessM = 0;
        step("to_sticky", FRZ | 14'd1);
        reset = 1;
        step("to_rst", RST | 14'd1);
        reset = 0;
        clear_inputs();
        step("to_after", IDLE);

        // Saturation of the stall counter
        memtoregE = 1; rtE = 2; rsD = 2;
        for (int i = 0; i < 20; i++) step("sat_stall", STL);
        clear_inputs();
        step("sat_hold", IDLE);
        check("sat_value", 32'(stallcount), 32'd15);

        // Random combinational hazards in RUN
        for (int i = 0; i < 40; i++) begin
            rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3));
            writeregM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3));
            regwriteE = 1'($urandom_range(0, 1)); regwriteM = 1'($urandom_range(0, 1));
            regwriteW = 1'($urandom_range(0, 1));
            memtoregE = 1'($urandom_range(0, 1)); memtoregM = 1'($urandom_range(0, 1));
            branchD = 1'($urandom_range(0, 1)); jumpD = 1'($urandom_range(0, 1));
            pcsrcD = 1'($urandom_range(0, 1));
            memaccessM = 0; memreadyM = 1'($urandom_range(0, 1));
            step("rand", model_run());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
